// File: rtl/bp_fe_lce_resp_arbiter.sv
// bp_fe_lce_resp_arbiter
//   Shares the single FE LCE->CCE response channel between the LCE request
//   engine (R: transfer/writeback responses) and the LCE command engine
//   (C: sync/invalidate acks). The output is a one-entry registered slot, so
//   there is no combinational path from the source packets to lce_resp_o.
//   R wins by default; C is forced through after losing starve_limit_p
//   consecutive contended grants (starve_limit_p=0 gives C strict priority).
//
// Ports
//   clk_i, reset_i                  clock, synchronous active-high reset
//   r_resp_i/_v_i/_yumi_o           request-engine packet, valid, consumed
//   c_resp_i/_v_i/_yumi_o           command-engine packet, valid, consumed
//   lce_resp_o/_v_o/_ready_i        registered packet to the network
module bp_fe_lce_resp_arbiter #(
  parameter int resp_width_p   = 8,
  parameter int starve_limit_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [resp_width_p-1:0] r_resp_i,
  input  logic                    r_resp_v_i,
  output logic                    r_resp_yumi_o,
  input  logic [resp_width_p-1:0] c_resp_i,
  input  logic                    c_resp_v_i,
  output logic                    c_resp_yumi_o,
  output logic [resp_width_p-1:0] lce_resp_o,
  output logic                    lce_resp_v_o,
  input  logic                    lce_resp_ready_i
);

  localparam int cnt_width_lp = (starve_limit_p + 1 > 1) ? $clog2(starve_limit_p + 1) : 1;
  localparam logic [cnt_width_lp-1:0] limit_lp = cnt_width_lp'(starve_limit_p);

  logic                    full_r;
  logic [resp_width_p-1:0] data_r;
  logic [cnt_width_lp-1:0] starve_cnt_r;

  logic slot_free, force_c, grant_c, grant_r;

  // Grants depend only on valids and state, never on packet contents.
  always_comb begin
    slot_free = ~full_r | lce_resp_ready_i;
    force_c   = c_resp_v_i & (starve_cnt_r >= limit_lp);
    grant_c   = c_resp_v_i & (force_c | ~r_resp_v_i);
    grant_r   = r_resp_v_i & ~grant_c;
  end

  // Gated by reset so no packet is dropped by the sources while the slot
  // is being cleared.
  assign r_resp_yumi_o = ~reset_i & slot_free & grant_r;
  assign c_resp_yumi_o = ~reset_i & slot_free & grant_c;

  assign lce_resp_o   = data_r;
  assign lce_resp_v_o = full_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_r       <= 1'b0;
      data_r       <= '0;
      starve_cnt_r <= '0;
    end else begin
      // A new grant in the same cycle as ready reloads the slot (no bubble).
      if (r_resp_yumi_o | c_resp_yumi_o) begin
        full_r <= 1'b1;
        data_r <= c_resp_yumi_o ? c_resp_i : r_resp_i;
      end else if (lce_resp_ready_i) begin
        full_r <= 1'b0;
      end

      // Only real contended losses count; stalled cycles leave it alone.
      // A C withdrawal clears it, since C is no longer waiting.
      if (slot_free) begin
        if (r_resp_yumi_o & c_resp_v_i) begin
          if (starve_cnt_r < limit_lp)
            starve_cnt_r <= starve_cnt_r + cnt_width_lp'(1);
        end else if (c_resp_yumi_o | ~c_resp_v_i) begin
          starve_cnt_r <= '0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  // A source may withdraw (drop v) but must not change a pending packet.
  c_stable_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (c_resp_v_i & ~c_resp_yumi_o) |=> (~c_resp_v_i | $stable(c_resp_i)));
  r_stable_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (r_resp_v_i & ~r_resp_yumi_o) |=> (~r_resp_v_i | $stable(r_resp_i)));
  yumi_excl_a: assert property (@(posedge clk_i)
    ~(r_resp_yumi_o & c_resp_yumi_o));
`endif

endmodule

// File: tb/tb_bp_fe_lce_resp_arbiter.sv
module tb_bp_fe_lce_resp_arbiter;

  logic       clk;
  logic       rst;
  logic       rv, cv, rdy, ry, cy, ov;
  logic [7:0] rd, cd, od;
  logic       r0v, c0v, r0y, c0y, o0v;
  logic [7:0] r0d, c0d, o0d;

  int errs   = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bp_fe_lce_resp_arbiter #(.resp_width_p(8), .starve_limit_p(4)) dut (
    .clk_i(clk), .reset_i(rst),
    .r_resp_i(rd), .r_resp_v_i(rv), .r_resp_yumi_o(ry),
    .c_resp_i(cd), .c_resp_v_i(cv), .c_resp_yumi_o(cy),
    .lce_resp_o(od), .lce_resp_v_o(ov), .lce_resp_ready_i(rdy)
  );

  bp_fe_lce_resp_arbiter #(.resp_width_p(8), .starve_limit_p(0)) dut0 (
    .clk_i(clk), .reset_i(rst),
    .r_resp_i(r0d), .r_resp_v_i(r0v), .r_resp_yumi_o(r0y),
    .c_resp_i(c0d), .c_resp_v_i(c0v), .c_resp_yumi_o(c0y),
    .lce_resp_o(o0d), .lce_resp_v_o(o0v), .lce_resp_ready_i(1'b1)
  );

  typedef struct {
    logic       rst, rv;
    logic [7:0] rd;
    logic       cv;
    logic [7:0] cd;
    logic       rdy, ery, ecy, chk, ev;
    logic [7:0] ed;
    int         ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst_, input logic rv_, input logic [7:0] rd_,
                     input logic cv_, input logic [7:0] cd_, input logic rdy_,
                     input logic ery_, input logic ecy_, input logic chk_,
                     input logic ev_, input logic [7:0] ed_, input int ecnt_);
    vec_t e;
    e.rst = rst_; e.rv = rv_; e.rd = rd_; e.cv = cv_; e.cd = cd_; e.rdy = rdy_;
    e.ery = ery_; e.ecy = ecy_; e.chk = chk_; e.ev = ev_; e.ed = ed_; e.ecnt = ecnt_;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0d: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rv = 0; cv = 0; rd = 0; cd = 0; rdy = 1'b1;
    r0v = 0; c0v = 0; r0d = 8'h50; c0d = 8'h60;

    //   rst rv rd    cv cd    rdy ry cy chk v  data  cnt
    // reset hold with both sources valid
    add(1, 1, 8'h01, 1, 8'h02, 1, 0, 0, 0, 0, 8'h00, 0);
    add(1, 1, 8'h01, 1, 8'h02, 1, 0, 0, 1, 0, 8'h00, 0);
    add(1, 1, 8'h01, 1, 8'h02, 1, 0, 0, 1, 0, 8'h00, 0);
    // R alone, back-to-back
    add(0, 1, 8'h0A, 0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0);
    add(0, 1, 8'h0B, 0, 8'h00, 1, 1, 0, 1, 1, 8'h0A, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 1, 8'h0B, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 8'h0B, 0);
    // C with backpressure
    add(0, 0, 8'h00, 1, 8'h05, 0, 0, 1, 1, 0, 8'h0B, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 8'h05, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 8'h05, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 8'h05, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 1, 8'h05, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 8'h05, 0);
    // starvation: R,R,R,R,C,R,R,R,R,C
    add(0, 1, 8'h10, 1, 8'h20, 1, 1, 0, 1, 0, 8'h05, 0);
    add(0, 1, 8'h11, 1, 8'h20, 1, 1, 0, 1, 1, 8'h10, 1);
    add(0, 1, 8'h12, 1, 8'h20, 1, 1, 0, 1, 1, 8'h11, 2);
    add(0, 1, 8'h13, 1, 8'h20, 1, 1, 0, 1, 1, 8'h12, 3);
    add(0, 1, 8'h14, 1, 8'h20, 1, 0, 1, 1, 1, 8'h13, 4);
    add(0, 1, 8'h14, 1, 8'h21, 1, 1, 0, 1, 1, 8'h20, 0);
    add(0, 1, 8'h15, 1, 8'h21, 1, 1, 0, 1, 1, 8'h14, 1);
    add(0, 1, 8'h16, 1, 8'h21, 1, 1, 0, 1, 1, 8'h15, 2);
    add(0, 1, 8'h17, 1, 8'h21, 1, 1, 0, 1, 1, 8'h16, 3);
    add(0, 1, 8'h18, 1, 8'h21, 1, 0, 1, 1, 1, 8'h17, 4);
    // C withdraws while losing: counter clears
    add(0, 1, 8'h18, 1, 8'h22, 1, 1, 0, 1, 1, 8'h21, 0);
    add(0, 1, 8'h19, 1, 8'h22, 1, 1, 0, 1, 1, 8'h18, 1);
    add(0, 1, 8'h1A, 0, 8'h00, 1, 1, 0, 1, 1, 8'h19, 2);
    add(0, 1, 8'h1B, 1, 8'h22, 1, 1, 0, 1, 1, 8'h1A, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 1, 8'h1B, 1);
    // both valid, slot full, no ready: nothing moves, counter holds
    add(0, 1, 8'h30, 1, 8'h40, 0, 1, 0, 1, 0, 8'h1B, 0);
    add(0, 1, 8'h31, 1, 8'h40, 0, 0, 0, 1, 1, 8'h30, 1);
    add(0, 1, 8'h31, 1, 8'h40, 0, 0, 0, 1, 1, 8'h30, 1);
    // ready and new grant together: reload without bubble
    add(0, 1, 8'h31, 1, 8'h40, 1, 1, 0, 1, 1, 8'h30, 1);
    add(0, 0, 8'h00, 1, 8'h40, 1, 0, 1, 1, 1, 8'h31, 2);
    add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 1, 8'h40, 0);
    // reset during a stall discards the held packet
    add(0, 1, 8'h07, 0, 8'h00, 0, 1, 0, 1, 0, 8'h40, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 8'h07, 0);
    add(1, 1, 8'h08, 0, 8'h00, 0, 0, 0, 1, 1, 8'h07, 0);
    add(0, 1, 8'h08, 1, 8'h09, 0, 1, 0, 1, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 1, 8'h08, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 8'h08, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; rv = tbl[i].rv; rd = tbl[i].rd;
      cv = tbl[i].cv; cd = tbl[i].cd; rdy = tbl[i].rdy;
      #4;
      chk("r_yumi", i, int'(ry), int'(tbl[i].ery));
      chk("c_yumi", i, int'(cy), int'(tbl[i].ecy));
      if (tbl[i].chk) begin
        chk("v_o", i, int'(ov), int'(tbl[i].ev));
        chk("data_o", i, int'(od), int'(tbl[i].ed));
        chk("starve_cnt", i, int'(dut.starve_cnt_r), tbl[i].ecnt);
      end
      @(posedge clk);
    end

    // starve_limit_p = 0: C wins whenever valid
    begin
      logic sr[7] = '{1, 1, 1, 1, 0, 1, 0};
      logic sc[7] = '{1, 1, 0, 1, 1, 0, 0};
      logic       pv = 1'b0;
      logic [7:0] pd = 8'h00;
      logic       er, ec;
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        r0v = sr[k]; c0v = sc[k];
        er = sr[k] & ~sc[k];
        ec = sc[k];
        #4;
        chk("l0_r_yumi", k, int'(r0y), int'(er));
        chk("l0_c_yumi", k, int'(c0y), int'(ec));
        chk("l0_v_o", k, int'(o0v), int'(pv));
        if (pv) chk("l0_data_o", k, int'(o0d), int'(pd));
        pv = er | ec;
        if (ec) pd = c0d; else if (er) pd = r0d;
        @(posedge clk);
        #1;
        if (er) r0d = r0d + 8'h01;
        if (ec) c0d = c0d + 8'h01;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
